qconv_sequencer: RTL and testbench
==================================

# qconv_sequencer

Runtime-configurable loop sequencer for the quantized convolution pipeline. It walks three nested loops: output-channel tiles (outer), then input row tiles and input column tiles (inner). On each loop pass it triggers the sub-engines (thresholds, read-indata, init-outbuf, khw, output) and waits for them with sticky done flags. Loop bounds are latched at `start`, so one netlist serves every layer shape. It sits between the layer controller and the datapath engines.

## Interface
Parameters:
- `OC_W`, default 8: width of the oc tile counter and bound.
- `IH_W`, default 8: width of the ih tile counter and bound.
- `IW_W`, default 8: width of the iw tile counter and bound.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; honoured only when idle.
- `oc_num`  in  OC_W  oc tile count, latched at start.
- `ih_num`  in  IH_W  ih tile count, latched at start.
- `iw_num`  in  IW_W  iw tile count, latched at start.
- `busy`  out  1  high while the outer FSM is not idle.
- `done`  out  1  one-cycle pulse when the whole layer completes.
- `oc_idx`  out  OC_W  current oc tile index.
- `ih_idx`  out  IH_W  current ih tile index.
- `iw_idx`  out  IW_W  current iw tile index.
- `thr_start`, `out_start`  out  1  pulses to the thresholds and output engines.
- `thr_done`, `out_done`  in  1  completion pulses from those engines.
- `rd_start`, `ob_start`, `khw_start`  out  1  pulses to the read-indata, init-outbuf and khw engines.
- `rd_done`, `ob_done`, `khw_done`  in  1  completion pulses from those engines.

## Operation
- Outer FSM states:
  - O_IDLE: on `start` with all bounds nonzero → O_TRIG.
  - O_TRIG: pulse `thr_start` and the internal inner-loop start → O_WAIT.
  - O_WAIT: when both the thr flag and the inner-finish flag are set → O_OTRIG.
  - O_OTRIG: pulse `out_start` → O_OWAIT.
  - O_OWAIT: when the out flag is set → O_NEXT.
  - O_NEXT: if `oc_idx` == oc_num−1 → O_IDLE and pulse `done`; otherwise increment `oc_idx` → O_TRIG.
- Inner FSM states:
  - I_IDLE: on the inner start → I_TRIG.
  - I_TRIG: pulse `rd_start` and `ob_start` → I_WAIT.
  - I_WAIT: when both the rd and ob flags are set → I_KTRIG.
  - I_KTRIG: pulse `khw_start` → I_KWAIT.
  - I_KWAIT: when the khw flag is set → I_NEXT.
  - I_NEXT:
    - if last (ih_idx == ih_num−1 and iw_idx == iw_num−1): pulse inner-finish → I_IDLE.
    - otherwise: advance iw_idx; on iw wrap, clear iw_idx and increment ih_idx; → I_TRIG.
- Sticky done flags:
  - One per engine, plus one for inner-finish.
  - Set by a done pulse in any non-idle state of the owning FSM, including a pulse in the same cycle as its trigger.
  - Cleared when the owning FSM enters its NEXT state.
- Done pulses arriving while the owning FSM is idle are ignored.
- Index counters:
  - `ih_idx` and `iw_idx` clear when the inner FSM is in I_IDLE.
  - `oc_idx` clears when the outer FSM is in O_IDLE.
- `start` while `busy` is ignored; latched bounds are unchanged.
- Zero bound: if any of oc_num, ih_num or iw_num is 0 at start, no engine is triggered. `done` pulses on the next cycle and `busy` stays 0.
- Bounds equal to 2^W−1 must work; the counters never overflow.

## Timing
- Reset values: `busy`=0, `done`=0, all `*_start`=0, all indices=0, both FSMs idle, all flags 0.
- Reset asserted mid-layer: everything returns to the reset values at once. No `done` is produced, and sub-engine pulses in flight are dropped.
- Every trigger is exactly one cycle wide.
- Latency with engines that answer in their trigger cycle, 1×1×1 case (start sampled at cycle 0):
  - cycle 1: `thr_start`; cycle 2: `rd_start` and `ob_start`; cycle 4: `khw_start`.
  - cycle 8: `out_start`; cycle 10: `done`.
  - `busy` is high on cycles 1–10.
- Each additional inner iteration adds 5 cycles. Each additional oc iteration adds (inner cycles + 5).
- A new `start` is accepted on the cycle after `done`.

## Configuration
- `QCONV_SEQ_PERF_EN` defined:
  - adds output `cycle_count` [31:0].
  - clears on an accepted start and counts every cycle `busy` is high.
  - saturates at 0xFFFFFFFF and holds its value after `done`.
  - reset value 0.
- `QCONV_SEQ_PERF_EN` undefined: the port and its counter do not exist. All other behaviour is identical.

## Structure
- Package `qconv_seq_pkg` holds:
  - the enumerated state types for the outer and inner FSMs, each 3 bits;
  - the localparam state encodings.
- Sub-module `qconv_seq_inner` holds the inner FSM, its flags and the ih/iw counters. The top level holds the outer FSM, the bound latches and the optional performance counter.

## Test plan
- 1×1×1 bounds, engines that answer instantly → trigger pulses on cycles 1/2/2/4/8, `done` on cycle 10, `busy` high on cycles 1–10.
- oc=2, ih=2, iw=3, engines with random 0–7 cycle delays → each engine triggers the expected number of times: thr ×2, rd/ob/khw ×12, out ×2; (ih,iw) sequence (0,0),(0,1),(0,2),(1,0)… per oc; one `done`.
- `thr_done` arrives 20 cycles after inner-finish, and `rd_done` in the same cycle as `rd_start` → no deadlock; `out_start` only after both flags are set.
- ih_num=0 → `done` on cycle 1, no `*_start` pulses, `busy` stays 0. Also `start` while busy → ignored, trigger count unchanged.
- `rst_n` low for 1 cycle during I_KWAIT → all outputs return to reset values, no `done`; a subsequent `start` runs cleanly. With `QCONV_SEQ_PERF_EN`, `cycle_count` reads 10 after the 1×1×1 run.

Source files
------------

// File: rtl/qconv_seq_pkg.sv
// qconv_seq_pkg: state encodings and FSM state types shared by the qconv sequencer.
package qconv_seq_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_TRIG  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_XTRIG = 3'd3;
  localparam logic [2:0] ST_XWAIT = 3'd4;
  localparam logic [2:0] ST_NEXT  = 3'd5;
  typedef enum logic [2:0] {
    O_IDLE = ST_IDLE, O_TRIG = ST_TRIG, O_WAIT = ST_WAIT,
    O_OTRIG = ST_XTRIG, O_OWAIT = ST_XWAIT, O_NEXT = ST_NEXT
  } outer_t;
  typedef enum logic [2:0] {
    I_IDLE = ST_IDLE, I_TRIG = ST_TRIG, I_WAIT = ST_WAIT,
    I_KTRIG = ST_XTRIG, I_KWAIT = ST_XWAIT, I_NEXT = ST_NEXT
  } inner_t;
endpackage

// File: rtl/qconv_seq_inner.sv
// qconv_seq_inner: ih/iw tile loop driving the read-indata, init-outbuf and khw engines.
module qconv_seq_inner
  import qconv_seq_pkg::*;
#(
  parameter int IH_W = 8,
  parameter int IW_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IH_W-1:0] ih_num,
  input  logic [IW_W-1:0] iw_num,
  input  logic            rd_done,
  input  logic            ob_done,
  input  logic            khw_done,
  output logic            rd_start,
  output logic            ob_start,
  output logic            khw_start,
  output logic            fin,
  output logic [IH_W-1:0] ih_idx,
  output logic [IW_W-1:0] iw_idx
);
  inner_t state;
  logic rd_f, ob_f, khw_f, iw_last, last;
  assign iw_last = iw_idx == iw_num - IW_W'(1);
  assign last = iw_last && ih_idx == ih_num - IH_W'(1);
  // Finish is combinational so the outer loop sees it in the I_NEXT cycle itself.
  assign fin = state == I_NEXT && last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= I_IDLE;
      rd_start <= 1'b0;
      ob_start <= 1'b0;
      khw_start <= 1'b0;
      rd_f <= 1'b0;
      ob_f <= 1'b0;
      khw_f <= 1'b0;
      ih_idx <= '0;
      iw_idx <= '0;
    end else begin
      rd_start <= 1'b0;
      ob_start <= 1'b0;
      khw_start <= 1'b0;
      if (state != I_IDLE) begin
        if (rd_done) rd_f <= 1'b1;
        if (ob_done) ob_f <= 1'b1;
        if (khw_done) khw_f <= 1'b1;
      end
      case (state)
        I_IDLE: begin
          ih_idx <= '0;
          iw_idx <= '0;
          if (start) begin
            state <= I_TRIG;
            rd_start <= 1'b1;
            ob_start <= 1'b1;
          end
        end
        I_TRIG: state <= I_WAIT;
        I_WAIT: if (rd_f && ob_f) begin
          state <= I_KTRIG;
          khw_start <= 1'b1;
        end
        I_KTRIG: state <= I_KWAIT;
        I_KWAIT: if (khw_f) begin
          state <= I_NEXT;
          rd_f <= 1'b0;
          ob_f <= 1'b0;
          khw_f <= 1'b0;
        end
        I_NEXT: if (last) state <= I_IDLE;
        else begin
          iw_idx <= iw_last ? '0 : iw_idx + IW_W'(1);
          ih_idx <= iw_last ? ih_idx + IH_W'(1) : ih_idx;
          state <= I_TRIG;
          rd_start <= 1'b1;
          ob_start <= 1'b1;
        end
        default: state <= I_IDLE;
      endcase
    end
endmodule

// File: rtl/qconv_sequencer.sv
// qconv_sequencer: oc/ih/iw loop sequencer for the quantized conv pipeline.
// Define QCONV_SEQ_PERF_EN to add the saturating busy-cycle counter cycle_count.
module qconv_sequencer
  import qconv_seq_pkg::*;
#(
  parameter int OC_W = 8,
  parameter int IH_W = 8,
  parameter int IW_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OC_W-1:0] oc_num,
  input  logic [IH_W-1:0] ih_num,
  input  logic [IW_W-1:0] iw_num,
  output logic            busy,
  output logic            done,
  output logic [OC_W-1:0] oc_idx,
  output logic [IH_W-1:0] ih_idx,
  output logic [IW_W-1:0] iw_idx,
  output logic            thr_start,
  output logic            out_start,
  input  logic            thr_done,
  input  logic            out_done,
  output logic            rd_start,
  output logic            ob_start,
  output logic            khw_start,
  input  logic            rd_done,
  input  logic            ob_done,
`ifdef QCONV_SEQ_PERF_EN
  output logic [31:0]     cycle_count,
`endif
  input  logic            khw_done
);
  outer_t state;
  logic [OC_W-1:0] oc_lim;
  logic [IH_W-1:0] ih_lim;
  logic [IW_W-1:0] iw_lim;
  logic thr_f, fin_f, out_f, fin, oc_last;
  assign busy = state != O_IDLE;
  assign oc_last = oc_idx == oc_lim - OC_W'(1);
  // The inner loop is kicked off together with the thresholds engine.
  qconv_seq_inner #(.IH_W(IH_W), .IW_W(IW_W)) u_inner (
    .clk(clk), .rst_n(rst_n), .start(thr_start), .ih_num(ih_lim), .iw_num(iw_lim),
    .rd_done(rd_done), .ob_done(ob_done), .khw_done(khw_done),
    .rd_start(rd_start), .ob_start(ob_start), .khw_start(khw_start),
    .fin(fin), .ih_idx(ih_idx), .iw_idx(iw_idx)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= O_IDLE;
      oc_idx <= '0;
      oc_lim <= '0;
      ih_lim <= '0;
      iw_lim <= '0;
      thr_start <= 1'b0;
      out_start <= 1'b0;
      done <= 1'b0;
      thr_f <= 1'b0;
      fin_f <= 1'b0;
      out_f <= 1'b0;
    end else begin
      thr_start <= 1'b0;
      out_start <= 1'b0;
      done <= 1'b0;
      if (state != O_IDLE) begin
        if (thr_done) thr_f <= 1'b1;
        if (fin) fin_f <= 1'b1;
        if (out_done) out_f <= 1'b1;
      end
      case (state)
        O_IDLE: begin
          oc_idx <= '0;
          if (start) begin
            oc_lim <= oc_num;
            ih_lim <= ih_num;
            iw_lim <= iw_num;
            if (oc_num == '0 || ih_num == '0 || iw_num == '0) done <= 1'b1;
            else begin
              state <= O_TRIG;
              thr_start <= 1'b1;
            end
          end
        end
        O_TRIG: state <= O_WAIT;
        O_WAIT: if (thr_f && fin_f) begin
          state <= O_OTRIG;
          out_start <= 1'b1;
        end
        O_OTRIG: state <= O_OWAIT;
        O_OWAIT: if (out_f) begin
          state <= O_NEXT;
          done <= oc_last;
          thr_f <= 1'b0;
          fin_f <= 1'b0;
          out_f <= 1'b0;
        end
        O_NEXT: if (oc_last) state <= O_IDLE;
        else begin
          oc_idx <= oc_idx + OC_W'(1);
          state <= O_TRIG;
          thr_start <= 1'b1;
        end
        default: state <= O_IDLE;
      endcase
    end
`ifdef QCONV_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cycle_count <= '0;
    else if (start && state == O_IDLE) cycle_count <= '0;
    else if (busy && cycle_count != '1) cycle_count <= cycle_count + 32'd1;
`endif
endmodule

// File: tb/tb_qconv_sequencer.sv
// tb_qconv_sequencer: directed runs with randomized engine latencies against a loop-level reference model.
module tb_qconv_sequencer;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] oc_num = '0, ih_num = '0, iw_num = '0;
  logic busy, done, thr_start, out_start, rd_start, ob_start, khw_start;
  logic thr_done, out_done, rd_done, ob_done, khw_done;
  logic [W-1:0] oc_idx, ih_idx, iw_idx;
  logic [31:0] cycle_count;
  logic [4:0] st, dn = '0, st_prev = '0;
  int dly_cfg[5] = '{0, 0, 0, 0, 0};
  int rem[5] = '{0, 0, 0, 0, 0};
  int cyc = 0, c0 = 0, ncmp = 0, nerr = 0;
  int cnt_trig[5], first_trig[5];
  int wide, done_cnt, done_rel, busy_cnt, busy_first, busy_last;
  logic [3*W-1:0] seq[$];

  qconv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .oc_num(oc_num), .ih_num(ih_num), .iw_num(iw_num),
    .busy(busy), .done(done), .oc_idx(oc_idx), .ih_idx(ih_idx), .iw_idx(iw_idx),
    .thr_start(thr_start), .out_start(out_start), .thr_done(thr_done), .out_done(out_done),
    .rd_start(rd_start), .ob_start(ob_start), .khw_start(khw_start),
    .rd_done(rd_done), .ob_done(ob_done),
`ifdef QCONV_SEQ_PERF_EN
    .cycle_count(cycle_count),
`endif
    .khw_done(khw_done)
  );
`ifndef QCONV_SEQ_PERF_EN
  assign cycle_count = '0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine index: 0 thr, 1 rd, 2 ob, 3 khw, 4 out. A negative latency means random 0..7.
  assign st = {out_start, khw_start, ob_start, rd_start, thr_start};
  assign {out_done, khw_done, ob_done, rd_done, thr_done} = dn;
  always @(negedge clk) begin
    int d;
    for (int e = 0; e < 5; e++) begin
      dn[e] = 1'b0;
      if (!rst_n) rem[e] = 0;
      else begin
        if (rem[e] > 0) begin
          rem[e]--;
          if (rem[e] == 0) dn[e] = 1'b1;
        end
        if (st[e]) begin
          d = dly_cfg[e] < 0 ? int'($urandom_range(7, 0)) : dly_cfg[e];
          if (d == 0) dn[e] = 1'b1;
          else rem[e] = d;
        end
      end
    end
  end

  always @(negedge clk) begin
    int rel;
    rel = cyc - c0;
    for (int e = 0; e < 5; e++)
      if (st[e]) begin
        cnt_trig[e]++;
        if (first_trig[e] < 0) first_trig[e] = rel;
        if (st_prev[e]) wide++;
      end
    st_prev = st;
    if (done) begin
      done_cnt++;
      done_rel = rel;
    end
    if (busy) begin
      busy_cnt++;
      if (busy_first < 0) busy_first = rel;
      busy_last = rel;
    end
    if (rd_start) seq.push_back({oc_idx, ih_idx, iw_idx});
  end

  task automatic clear_stats();
    for (int e = 0; e < 5; e++) begin
      cnt_trig[e] = 0;
      first_trig[e] = -1;
    end
    wide = 0; done_cnt = 0; done_rel = -1; busy_cnt = 0; busy_first = -1; busy_last = -1;
    seq.delete();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit seq_ok(input int o, input int i, input int w);
    int n = 0;
    if (seq.size() != o * i * w) return 1'b0;
    for (int a = 0; a < o; a++)
      for (int b = 0; b < i; b++)
        for (int c = 0; c < w; c++) begin
          if (seq[n] !== {W'(a), W'(b), W'(c)}) return 1'b0;
          n++;
        end
    return 1'b1;
  endfunction

  // Launch one layer; optionally fire a stray start with different bounds mid-run.
  task automatic run(input int o, input int i, input int w, input int budget, input bit inject);
    @(negedge clk);
    oc_num = W'(o); ih_num = W'(i); iw_num = W'(w);
    start = 1'b1;
    c0 = cyc;
    clear_stats();
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < budget && done_cnt == 0; k++) begin
      @(negedge clk);
      start = inject && k == 12;
      if (start) begin
        oc_num = 1; ih_num = 1; iw_num = 1;
      end
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("done_seen", done_cnt, 1);
  endtask

  initial begin
    clear_stats();
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_starts", int'(st), 0);
    chk("rst_idx", int'({oc_idx, ih_idx, iw_idx}), 0);
    rst_n = 1'b1;

    run(1, 1, 1, 50, 1'b0);
    chk("a_thr_cyc", first_trig[0], 1);
    chk("a_rd_cyc", first_trig[1], 2);
    chk("a_ob_cyc", first_trig[2], 2);
    chk("a_khw_cyc", first_trig[3], 4);
    chk("a_out_cyc", first_trig[4], 8);
    chk("a_done_cyc", done_rel, 10);
    chk("a_busy_cnt", busy_cnt, 10);
    chk("a_busy_first", busy_first, 1);
    chk("a_busy_last", busy_last, 10);
`ifdef QCONV_SEQ_PERF_EN
    chk("a_cycle_count", int'(cycle_count), 10);
`endif

    run(1, 0, 3, 50, 1'b0);
    chk("z_done_cyc", done_rel, 1);
    chk("z_busy_cnt", busy_cnt, 0);
    chk("z_trigs", cnt_trig[0] + cnt_trig[1] + cnt_trig[2] + cnt_trig[3] + cnt_trig[4], 0);

    dly_cfg = '{-1, -1, -1, -1, -1};
    for (int r = 0; r < 3; r++) begin
      run(2, 2, 3, 3000, r == 0);
      chk("r_thr_cnt", cnt_trig[0], 2);
      chk("r_rd_cnt", cnt_trig[1], 12);
      chk("r_ob_cnt", cnt_trig[2], 12);
      chk("r_khw_cnt", cnt_trig[3], 12);
      chk("r_out_cnt", cnt_trig[4], 2);
      chk("r_seq", int'(seq_ok(2, 2, 3)), 1);
      chk("r_wide", wide, 0);
    end

    dly_cfg = '{25, 0, 0, 0, 0};
    run(1, 1, 1, 100, 1'b0);
    chk("d_out_cyc", first_trig[4], 28);
    chk("d_done_cyc", done_rel, 30);

    dly_cfg = '{0, 0, 0, 0, 0};
    run(2, 2, 3, 500, 1'b0);
    chk("e_done_cyc", done_rel, 2 * (5 * 6 + 5));
    run(1, 1, 255, 3000, 1'b0);
    chk("f_done_cyc", done_rel, 5 * 255 + 5);
    chk("f_rd_cnt", cnt_trig[1], 255);
    chk("f_seq", int'(seq_ok(1, 1, 255)), 1);
    run(255, 1, 1, 3000, 1'b0);
    chk("g_done_cyc", done_rel, 255 * 10);
    chk("g_thr_cnt", cnt_trig[0], 255);
    chk("g_seq", int'(seq_ok(255, 1, 1)), 1);

    dly_cfg = '{0, 0, 0, 6, 0};
    @(negedge clk);
    oc_num = 1; ih_num = 1; iw_num = 1;
    start = 1'b1;
    c0 = cyc;
    clear_stats();
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50 && first_trig[3] < 0; k++) @(negedge clk);
    chk("h_khw_cyc", first_trig[3], 4);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("h_busy", int'(busy), 0);
    chk("h_done", int'(done), 0);
    chk("h_starts", int'(st), 0);
    chk("h_idx", int'({oc_idx, ih_idx, iw_idx}), 0);
    chk("h_cycle_count", int'(cycle_count), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    clear_stats();
    repeat (20) @(negedge clk);
    chk("h_no_done", done_cnt, 0);
    chk("h_no_trig", cnt_trig[0] + cnt_trig[1] + cnt_trig[2] + cnt_trig[3] + cnt_trig[4], 0);
    dly_cfg = '{0, 0, 0, 0, 0};
    run(1, 1, 1, 50, 1'b0);
    chk("h2_rd_cyc", first_trig[1], 2);
    chk("h2_done_cyc", done_rel, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
